intpol2_d4_fwd_diff_gen: RTL and testbench
==========================================

Name: intpol2_D4_fwd_diff_gen

Overview:
Forward-difference sample generator for the second-order interpolator datapath. It is the reconstruction end of the difference (subtract) stage.
- Accepts one coefficient set per input sample: base value y0, first difference d1, second difference d2.
- Emits 2^STEP_LOG2 interpolated samples by repeated accumulation: y += d1, then d1 += d2.
- Sits between the coefficient/difference stage and the output sample stream; valid/ready handshake on both sides.

Parameters:
- DATAPATH_WIDTH, 32, fractional/data bits of each sample.
- N_bits, 2, extra integer guard bits; every sample bus is DATAPATH_WIDTH+N_bits wide (W below).
- STEP_LOG2, 2, log2 of the number of output samples per loaded set (default gives 4).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, all state holds and both handshakes stall.
- load_valid  in  1  coefficient set present.
- load_ready  out  1  block can accept a set this cycle.
- y0  in  W signed  base sample.
- d1  in  W signed  first forward difference.
- d2  in  W signed  second forward difference.
- out_valid  out  1  y_out holds a valid sample.
- out_ready  in  1  downstream accepts y_out.
- y_out  out  W signed  interpolated sample.
- out_last  out  1  high with the final sample of a set.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; y, acc1, acc2, cnt = 0; out_valid=0; out_last=0; y_out=0. load_ready is combinational, =1 in IDLE with en=1.
- States: IDLE, RUN.
- Load handshake: load_ready = en & (IDLE | (RUN & out_last & out_ready)). On load_valid & load_ready:
  - y<=y0, acc1<=d1, acc2<=d2, cnt<=0, state<=RUN.
- Latency: first sample (y0) is on y_out the cycle after load acceptance.
- RUN: out_valid = en; y_out = y register; out_last = (cnt == 2^STEP_LOG2-1).
- On out_valid & out_ready, not last:
  - y<=y+acc1, acc1<=acc1+acc2, acc2 holds, cnt<=cnt+1.
  - Both sums use pre-update register values in the same cycle.
- On out_valid & out_ready with out_last:
  - If a load is also accepted in that cycle, the new set is captured and the block stays in RUN (zero-bubble back-to-back sets).
  - Otherwise state<=IDLE.
- out_valid & !out_ready: all registers hold; y_out and out_last stable (AXI-style, no retraction).
- Arithmetic: two's-complement, width W. Sums wrap modulo 2^W with no saturation and no overflow flag.
- en=0: no register changes; out_valid=0 and load_ready=0 are forced.
- cnt is STEP_LOG2 bits (minimum 1). It wraps only through reload.
- Reset mid-RUN aborts the set immediately; no partial flush.

Decomposition:
- Shared package intpol2_D4_pkg:
  - state encoding (IDLE=0, RUN=1);
  - localparam helper for W = DATAPATH_WIDTH+N_bits.
- Sub-module intpol2_D4_add_sync: registered signed adder with enable and load-mux. Instantiated twice: y/acc1 path and acc1/acc2 path.
- FSM and counter stay in the top module.

Test Plan:
- Basic set: STEP_LOG2=2, y0=10, d1=3, d2=1, out_ready=1 -> y_out=10,13,17,22 on 4 consecutive cycles; out_last only with 22; then load_ready=1.
- Backpressure: same set, out_ready low on cycles 2-3 -> 13 held stable with out_valid=1; sequence unchanged; total 6 cycles.
- Back-to-back: second set (y0=-5, d1=-2, d2=0) presented with load_valid held -> accepted on the cycle 22 is consumed; next cycle y_out=-5, then -7, -9, -11; no idle gap.
- Wrap: W=34, y0=2^33-1, d1=1, d2=0 -> second sample = -2^33 exactly.
- en gating: en=0 for 3 cycles mid-set -> out_valid=0, load_ready=0, no state change; resumes at the same sample.
- Reset mid-RUN: assert rst after 2 samples -> out_valid=0, y_out=0 asynchronously. After release, IDLE with load_ready=1; a new set starts from its own y0.

Source files
------------

// File: rtl/intpol2_d4_pkg.sv
// Shared types and width helpers for the intpol2 D4 stage.
// The state encoding and the sample bus width are defined here.
package intpol2_d4_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DEF_DATAPATH_WIDTH = 32;
   localparam int DEF_N_BITS         = 2;

   function automatic int calc_w(input int dw, input int nb);
      return dw + nb;
   endfunction

   localparam int DEF_W = calc_w(DEF_DATAPATH_WIDTH, DEF_N_BITS);

endpackage

// File: rtl/intpol2_d4_add_sync.sv
// Registered signed accumulator with a load mux; load wins over add.
// The sum wraps modulo 2^W.
module intpol2_d4_add_sync #(
   parameter int W = 34
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld,
   input  logic                add,
   input  logic signed [W-1:0] ld_val,
   input  logic signed [W-1:0] inc,
   output logic signed [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (ld) begin
         q <= ld_val;
      end else if (add) begin
         q <= q + inc;
      end
   end

endmodule

// File: rtl/intpol2_d4_fwd_diff_gen.sv
// Forward-difference generator: 2^STEP_LOG2 samples per loaded set,
// y += d1 then d1 += d2, with valid/ready handshakes on both sides.
module intpol2_d4_fwd_diff_gen
   import intpol2_d4_pkg::*;
#(
   parameter  int DATAPATH_WIDTH = 32,
   parameter  int N_bits         = 2,
   parameter  int STEP_LOG2      = 2,
   localparam int W              = calc_w(DATAPATH_WIDTH, N_bits)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic signed [W-1:0] y0,
   input  logic signed [W-1:0] d1,
   input  logic signed [W-1:0] d2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] y_out,
   output logic                out_last
);

   localparam int CW = (STEP_LOG2 < 1) ? 1 : STEP_LOG2;
   localparam logic [CW-1:0] CMAX = CW'((1 << STEP_LOG2) - 1);

   state_e              state_q;
   state_e              state_d;
   logic [CW-1:0]       cnt_q;
   logic signed [W-1:0] y_q;
   logic signed [W-1:0] acc1_q;
   logic signed [W-1:0] acc2_q;
   logic                run;
   logic                out_fire;
   logic                load_fire;
   logic                step;

   assign run        = (state_q == RUN);
   assign out_valid  = en & run;
   assign out_last   = run & (cnt_q == CMAX);
   assign load_ready = en & (~run | (out_last & out_ready));
   assign out_fire   = out_valid & out_ready;
   assign load_fire  = load_valid & load_ready;
   assign step       = out_fire & ~out_last;
   assign y_out      = y_q;

   // a load coinciding with the last sample keeps RUN for zero-bubble sets
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (load_fire) state_d = RUN;
         RUN: begin
            if (out_fire & out_last & ~load_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc2_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_fire) begin
            cnt_q  <= '0;
            acc2_q <= d2;
         end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   intpol2_d4_add_sync #(.W(W)) u_y (
      .clk    (clk),
      .rst    (rst),
      .ld     (load_fire),
      .add    (step),
      .ld_val (y0),
      .inc    (acc1_q),
      .q      (y_q)
   );

   intpol2_d4_add_sync #(.W(W)) u_acc1 (
      .clk    (clk),
      .rst    (rst),
      .ld     (load_fire),
      .add    (step),
      .ld_val (d1),
      .inc    (acc2_q),
      .q      (acc1_q)
   );

endmodule

// File: tb/tb_intpol2_d4_fwd_diff_gen.sv
// Scoreboard bench for intpol2_d4_fwd_diff_gen with directed sets.
// Expected samples are queued at stimulus time and popped by a monitor.
module tb_intpol2_d4_fwd_diff_gen;

   localparam int W = 34;

   typedef struct packed {
      logic signed [W-1:0] y;
      logic                last;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                en;
   logic                load_valid;
   logic                load_ready;
   logic signed [W-1:0] y0;
   logic signed [W-1:0] d1;
   logic signed [W-1:0] d2;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] y_out;
   logic                out_last;

   exp_t q[$];
   int   checks    = 0;
   int   fails     = 0;
   int   sb_checks = 0;
   int   sb_fails  = 0;

   always #5 clk = ~clk;

   intpol2_d4_fwd_diff_gen dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .y0         (y0),
      .d1         (d1),
      .d2         (d2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .y_out      (y_out),
      .out_last   (out_last)
   );

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         sb_checks++;
         if (q.size() == 0) begin
            sb_fails++;
            $display("FAIL sb_extra: got y=%0d last=%0b, none expected",
                     y_out, out_last);
         end else begin
            e = q.pop_front();
            if (y_out !== e.y || out_last !== e.last) begin
               sb_fails++;
               $display("FAIL sb_sample: got y=%0d last=%0b, want y=%0d last=%0b",
                        y_out, out_last, e.y, e.last);
            end
         end
      end
   end

   task automatic chk(input string nm,
                      input logic signed [W-1:0] got,
                      input logic signed [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, got, exp);
      end
   endtask

   task automatic push4(input logic signed [W-1:0] a,
                        input logic signed [W-1:0] b,
                        input logic signed [W-1:0] c,
                        input logic signed [W-1:0] d);
      q.push_back('{y: a, last: 1'b0});
      q.push_back('{y: b, last: 1'b0});
      q.push_back('{y: c, last: 1'b0});
      q.push_back('{y: d, last: 1'b1});
   endtask

   task automatic load_set(input logic signed [W-1:0] yv,
                           input logic signed [W-1:0] d1v,
                           input logic signed [W-1:0] d2v);
      bit got = 1'b0;
      @(negedge clk);
      y0 = yv;
      d1 = d1v;
      d2 = d2v;
      load_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (load_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("load_accept", got, 1);
      @(posedge clk);
      #1 load_valid = 1'b0;
      @(negedge clk);
      chk("first_valid", out_valid, 1);
      chk("first_y", y_out, yv);
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 60; k++) begin
         if (q.size() == 0) break;
         @(posedge clk);
      end
      #1 chk(nm, q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b1;
      load_valid = 1'b0;
      out_ready = 1'b1;
      y0 = '0;
      d1 = '0;
      d2 = '0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_y", y_out, 0);
      chk("rst_last", out_last, 0);
      chk("rst_load_ready", load_ready, 1);
      @(posedge clk);
      #1 rst = 1'b0;

      // basic set
      push4(10, 13, 17, 22);
      load_set(10, 3, 1);
      drain("basic_drain");
      @(negedge clk);
      chk("basic_idle_ready", load_ready, 1);
      chk("basic_idle_valid", out_valid, 0);

      // backpressure on the second sample
      push4(10, 13, 17, 22);
      load_set(10, 3, 1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid0", out_valid, 1);
      chk("bp_y0", y_out, 13);
      chk("bp_last0", out_last, 0);
      @(negedge clk);
      chk("bp_valid1", out_valid, 1);
      chk("bp_y1", y_out, 13);
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain("bp_drain");

      // back-to-back sets without a gap
      push4(10, 13, 17, 22);
      push4(-5, -7, -9, -11);
      load_set(10, 3, 1);
      load_set(-5, -2, 0);
      drain("b2b_drain");

      // wrap at W=34
      push4(34'sh1_FFFF_FFFF, 34'sh2_0000_0000,
            34'sh2_0000_0001, 34'sh2_0000_0002);
      load_set(34'sh1_FFFF_FFFF, 1, 0);
      drain("wrap_drain");

      // enable gating mid-set
      push4(0, 5, 12, 21);
      load_set(0, 5, 2);
      @(posedge clk);
      #1 en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("en_valid", out_valid, 0);
         chk("en_load_ready", load_ready, 0);
         chk("en_y_hold", y_out, 5);
      end
      @(posedge clk);
      #1 en = 1'b1;
      drain("en_drain");

      // reset mid-run after two samples
      q.push_back('{y: 100, last: 1'b0});
      q.push_back('{y: 101, last: 1'b0});
      load_set(100, 1, 1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_y", y_out, 0);
      chk("mid_rst_last", out_last, 0);
      chk("mid_rst_queue", q.size(), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", load_ready, 1);
      chk("post_rst_valid", out_valid, 0);
      push4(-3, 1, 4, 6);
      load_set(-3, 4, -1);
      drain("post_rst_drain");

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks + sb_checks, fails + sb_fails);
      $finish;
   end

endmodule
